// File: rtl/fp_spi_pkg.sv
// Shared types and constants for the front-panel SPI transmitter.
package fp_spi_pkg;

    // Bits per frame on the wire.
    localparam int unsigned FpSpiBits = 8;

    // SCLK level while the link is idle (CPOL = 0).
    localparam logic SclkIdle = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } fp_spi_state_e;

endpackage

// File: rtl/fp_spi_phase_tick.sv
// Loadable down-counter that paces every FSM state of the SPI transmitter.
// tc_o flags the last cycle of a state; pre_tc_o flags the cycle before it.
module fp_spi_phase_tick
    import fp_spi_pkg::*;
#(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             tc_o,
    output logic             pre_tc_o
);

    logic [Width-1:0] cnt_q;

    // Reload on state entry, otherwise count down and rest at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o     = (cnt_q == '0);
    assign pre_tc_o = (cnt_q == Width'(1));

endmodule

// File: rtl/fp_spi_tx.sv
// SPI master byte transmitter (mode 0, MSB first) for the front-panel link.
// Optional build macro FP_SPI_TX_BURST_EN: accept the next byte in the last HOLD
// cycle and keep SS low across frames instead of passing through GAP.
module fp_spi_tx
    import fp_spi_pkg::*;
#(
    parameter int unsigned ClkDiv = 2,
    parameter int unsigned SsGap  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] txdata_i,
    input  logic       txvalid_i,
    output logic       txready_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       ss_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CntMax = (ClkDiv > SsGap) ? ClkDiv : SsGap;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] PhaseLoad = CntW'(ClkDiv - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(SsGap - 1);

    fp_spi_state_e state_q;
    logic [7:0]    shreg_q;
    logic [3:0]    bitcnt_q;
    logic          sclk_q, mosi_q, ss_q, busy_q, done_q, txready_q;

    logic            hs, advance, last_bit, tc, pre_tc, cnt_load;
    logic [CntW-1:0] cnt_val;

    // Handshake detection and phase-counter reload on every state entry.
    always_comb begin
        hs       = txvalid_i & txready_q;
        advance  = (state_q != StIdle) & tc;
        cnt_load = hs | advance;
        cnt_val  = PhaseLoad;
        if ((state_q == StHold) && !hs) begin
            cnt_val = GapLoad;
        end
        last_bit = (bitcnt_q == 4'(FpSpiBits - 1));
    end

    fp_spi_phase_tick #(
        .Width (CntW)
    ) u_phase_tick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_o       (tc),
        .pre_tc_o   (pre_tc)
    );

`ifndef FP_SPI_TX_BURST_EN
    logic unused_pre_tc;
    assign unused_pre_tc = pre_tc;
`endif

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            sclk_q    <= SclkIdle;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            txready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (hs) begin
                        shreg_q   <= txdata_i;
                        mosi_q    <= txdata_i[7];
                        bitcnt_q  <= '0;
                        ss_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        txready_q <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup, StLow: begin
                    if (tc) begin
                        sclk_q  <= 1'b1;
                        state_q <= StHigh;
                    end
                end
                StHigh: begin
                    if (tc) begin
                        sclk_q   <= SclkIdle;
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (last_bit) begin
                            state_q <= StHold;
`ifdef FP_SPI_TX_BURST_EN
                            // A one-cycle HOLD is already its own last cycle.
                            txready_q <= (ClkDiv == 32'd1);
`endif
                        end else begin
                            shreg_q <= {shreg_q[6:0], 1'b0};
                            mosi_q  <= shreg_q[6];
                            state_q <= StLow;
                        end
                    end
                end
                StHold: begin
`ifdef FP_SPI_TX_BURST_EN
                    if (hs) begin
                        shreg_q   <= txdata_i;
                        mosi_q    <= txdata_i[7];
                        bitcnt_q  <= '0;
                        done_q    <= 1'b1;
                        txready_q <= 1'b0;
                        state_q   <= StSetup;
                    end else
`endif
                    if (tc) begin
                        ss_q      <= 1'b1;
                        mosi_q    <= 1'b0;
                        done_q    <= 1'b1;
                        txready_q <= 1'b0;
                        state_q   <= StGap;
                    end
`ifdef FP_SPI_TX_BURST_EN
                    else if (pre_tc) begin
                        txready_q <= 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (tc) begin
                        busy_q    <= 1'b0;
                        txready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign txready_o = txready_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign ss_o      = ss_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_fp_spi_tx.sv
// Scoreboard bench for fp_spi_tx: the driver queues every accepted byte, a monitor
// rebuilds bytes from MOSI at SCLK rises and checks them against the queue.
module tb_fp_spi_tx;

    localparam int unsigned ClkDiv  = 2;
    localparam int unsigned SsGap   = 4;
`ifdef FP_SPI_TX_BURST_EN
    localparam int ExpRun = 2;
`else
    localparam int ExpRun = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0] txdata  = 8'h00;
    logic       txvalid = 1'b0;
    logic       txready, sclk, mosi, ss, busy, done;

    logic [7:0] txdata1  = 8'h00;
    logic       txvalid1 = 1'b0;
    logic       txready1, sclk1, mosi1, ss1, busy1, done1;

    always #5 clk = ~clk;

    fp_spi_tx #(
        .ClkDiv (ClkDiv),
        .SsGap  (SsGap)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .txdata_i  (txdata),
        .txvalid_i (txvalid),
        .txready_o (txready),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .ss_o      (ss),
        .busy_o    (busy),
        .done_o    (done)
    );

    fp_spi_tx #(
        .ClkDiv (1),
        .SsGap  (2)
    ) dut1 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .txdata_i  (txdata1),
        .txvalid_i (txvalid1),
        .txready_o (txready1),
        .sclk_o    (sclk1),
        .mosi_o    (mosi1),
        .ss_o      (ss1),
        .busy_o    (busy1),
        .done_o    (done1)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    int         nbits, ss_low_len, ss_high_len, run_frames, last_run_frames;
    int         proto_err = 0;
    bit         first_gap;
    logic [7:0] bits, e;
    logic       sclk_p, ss_p, mosi_p, done_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits       = 0;
            bits        = 8'h00;
            ss_low_len  = 0;
            ss_high_len = 0;
            run_frames  = 0;
            first_gap   = 1'b1;
            sclk_p      = 1'b0;
            ss_p        = 1'b1;
            mosi_p      = 1'b0;
            done_p      = 1'b0;
        end else begin
            if (sclk && ss) proto_err++;
            if (sclk && sclk_p && (mosi != mosi_p)) proto_err++;
            if (done && done_p) proto_err++;
`ifndef FP_SPI_TX_BURST_EN
            if (txready && (!ss || busy)) proto_err++;
`endif
            if (sclk && !sclk_p) begin
                bits = {bits[6:0], mosi};
                nbits++;
            end
            if (done) begin
                check("bits_per_byte", nbits, 8);
                check("protocol", proto_err, 0);
                proto_err = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", int'(bits), int'(e));
                end
                nbits = 0;
                run_frames++;
            end
            if (!ss) begin
                if (ss_p) begin
                    if (!first_gap) check("ss_gap", int'(ss_high_len >= int'(SsGap)), 1);
                    first_gap = 1'b0;
                end
                ss_low_len++;
                ss_high_len = 0;
            end else begin
                if (!ss_p) begin
                    check("ss_low_len", ss_low_len, 17 * int'(ClkDiv) * run_frames);
                    last_run_frames = run_frames;
                end
                ss_low_len = 0;
                run_frames = 0;
                ss_high_len++;
            end
            sclk_p = sclk;
            ss_p   = ss;
            mosi_p = mosi;
            done_p = done;
        end
    end

    // ----------------------------------------------------------------- driver
    // Entered at a negedge; returns at the negedge after the handshake, valid still high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        txvalid = 1'b1;
        txdata  = b;
        while (!txready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("handshake_timeout", 0, 1);
        end else begin
            exp_q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !ss || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", int'(busy), 0);
        check("pending_bytes", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   k, rises, rises1, first1, last1, low1;
    logic sp, seen1, ready_seen;
    logic [7:0] bits1;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txready", int'(txready), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_ss", int'(ss), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ss1", int'(ss1), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, then time the GAP until BUSY drops.
        send_byte(8'hA5);
        txvalid = 1'b0;
        wait_done();
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("gap_len", k, int'(SsGap));
        check("ready_after_gap", int'(txready), 1);
        wait_idle();

        // Valid held across two bytes: separate frames, or one SS run in burst builds.
        send_byte(8'h00);
        send_byte(8'hFF);
        txvalid = 1'b0;
        wait_idle();
        check("run_frames_00_ff", last_run_frames, ExpRun);
        send_byte(8'h3C);
        send_byte(8'hC3);
        txvalid = 1'b0;
        wait_idle();
        check("run_frames_3c_c3", last_run_frames, ExpRun);

        // Junk on TXVALID/TXDATA mid-frame must be ignored.
        send_byte(8'h00);
        ready_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            txvalid = 1'($urandom_range(0, 1));
            txdata  = 8'hFF;
            ready_seen = ready_seen | txready;
            @(negedge clk);
        end
        txvalid = 1'b0;
        check("ready_mid_frame", int'(ready_seen), 0);
        wait_idle();

        // Reset after the third SCLK rise drops the byte without DONE.
        send_byte(8'h33);
        txvalid = 1'b0;
        rises = 0;
        sp    = sclk;
        k     = 0;
        while (rises < 3 && k < 200) begin
            @(negedge clk);
            if (sclk && !sp) rises++;
            sp = sclk;
            k++;
        end
        check("rises_before_reset", rises, 3);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_ss", int'(ss), 1);
        check("midrst_sclk", int'(sclk), 0);
        check("midrst_mosi", int'(mosi), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(txready), 1);
        send_byte(8'h5A);
        txvalid = 1'b0;
        wait_idle();

        // Fastest divider: SCLK toggles every cycle.
        txvalid1 = 1'b1;
        txdata1  = 8'h81;
        check("ready1", int'(txready1), 1);
        @(negedge clk);
        txvalid1 = 1'b0;
        rises1 = 0;
        bits1  = 8'h00;
        first1 = -1;
        last1  = -1;
        low1   = 0;
        seen1  = 1'b0;
        sp     = 1'b0;
        for (int c = 0; c < 80 && !seen1; c++) begin
            if (sclk1 && !sp) begin
                bits1 = {bits1[6:0], mosi1};
                if (rises1 == 0) first1 = c;
                last1 = c;
                rises1++;
            end
            sp = sclk1;
            if (!ss1) low1++;
            if (done1) seen1 = 1'b1;
            @(negedge clk);
        end
        check("div1_done", int'(seen1), 1);
        check("div1_rises", rises1, 8);
        check("div1_byte", int'(bits1), 8'h81);
        check("div1_span", last1 - first1, 14);
        check("div1_ss_low", low1, 17);

        // Random traffic: any byte offered while TXREADY is high is accepted.
        for (int i = 0; i < 3000; i++) begin
            txvalid = ($urandom_range(0, 2) == 0);
            txdata  = 8'($urandom);
            if (txvalid && txready) exp_q.push_back(txdata);
            @(negedge clk);
        end
        txvalid = 1'b0;
        wait_idle();
        check("protocol_final", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
